restador_serie: RTL
===================

# restador_serie

Bit-serial subtractor computing `a - b - bi` one bit per clock through a single full-subtractor cell and a registered borrow. It uses a start/done handshake. It is the subtraction-side companion to the ripple adder in the arithmetic/power-analysis block set. It trades WIDTH+2 cycles of latency for one-cell area, which makes it the low-toggle reference point for power comparison against the parallel adder.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; legal range 2..32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `iniciar`  in  1  start request; sampled only while `listo`=1.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `bi`  in  1  borrow-in; captured on the accepting edge.
- `listo`  out  1  block idle and able to accept `iniciar`.
- `valido`  out  1  one-cycle pulse: `d`/`bo` updated with a new result.
- `d`  out  WIDTH  difference; holds its value between results.
- `bo`  out  1  borrow-out of MSB (1 = `a < b + bi`, unsigned).

## Operation
- States:
  - REPOSO: idle; `listo`=1.
  - CALCULO: serial processing.
  - FIN: result commit.
- In REPOSO with `iniciar`=1 at an edge:
  - load shift registers with `a` and `b`;
  - load borrow register with `bi`;
  - clear bit counter; go to CALCULO.
- Each edge in CALCULO, using LSBs `x` = a-shift[0] and `y` = b-shift[0] and borrow `r`:
  - difference bit = `x^y^r`, shifted into result-register MSB (shift right);
  - borrow' = `(~x & y) | (~(x^y) & r)`;
  - both operand shift registers shift right;
  - counter increments.
- On the edge where counter == WIDTH-1: last bit is processed and the state goes to FIN.
- On the edge in FIN: copy result register to `d` and borrow register to `bo`, set `valido`=1, go to REPOSO.
- Arithmetic is unsigned modulo 2^WIDTH. `bo` is the true borrow of the full WIDTH-bit subtraction.
- `iniciar` in CALCULO or FIN is ignored. It is neither queued nor an error.
- Changing `a`, `b` or `bi` after acceptance has no effect on the running operation.
- The counter is `$clog2(WIDTH)` bits and never wraps in normal use. It is cleared on every acceptance.

## Timing
- Reset values:
  - `listo`=1, `valido`=0, `d`=0, `bo`=0;
  - state REPOSO; counter, shift and borrow registers all 0.
- Reset asserted mid-operation: aborts immediately and asynchronously. No `valido` is produced and `d`/`bo` read 0.
- Edge numbering: acceptance edge = edge 0.
  - Bit i is processed at edge i+1.
  - FIN is entered at edge WIDTH.
  - `d`/`bo`/`valido` update at edge WIDTH+1.
- `valido` is high for exactly one cycle, from edge WIDTH+1 to edge WIDTH+2.
- `listo` falls at edge 0 and rises at edge WIDTH+1, in the same cycle as `valido`.
- Back-to-back: `iniciar` held high is accepted again at edge WIDTH+1? No. It is accepted at edge WIDTH+2, giving throughput of one result per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `RESTADOR_SERIE_SAT_EN`.
- Defined: unsigned saturation. When the final borrow is 1, `d` is committed as 0; `bo` still reports 1.
- Undefined: `d` wraps modulo 2^WIDTH (two's-complement difference bits).
- Latency, handshake and `bo` are identical in both builds.

## Test plan
- WIDTH=8, a=100, b=58, bi=0, `iniciar` pulse -> at edge 9: `valido`=1, `d`=42, `bo`=0; `listo`=1 the same cycle.
- a=5, b=10, bi=0 -> `bo`=1. `d`=251 without the macro; `d`=0 with `RESTADOR_SERIE_SAT_EN`.
- a=0x00, b=0x00, bi=1 -> `d`=0xFF, `bo`=1 (macro off). a=0xFF, b=0xFF, bi=0 -> `d`=0, `bo`=0.
- Start a=200, b=1; pulse `iniciar` with a=3, b=9 at edge 4 -> second request ignored; the single `valido` at edge 9 carries `d`=199, `bo`=0.
- Start an operation, assert `reset` asynchronously between edges 3 and 4 -> outputs immediately 0, `listo`=1, no `valido` after reset release. A new start then completes normally.
- `iniciar` held high with constant a=7, b=3 -> `valido` pulses at edges 9, 19, 29 (period 10), each with `d`=4.

Source files
------------

// File: rtl/restador_serie.sv
`default_nettype none
// ============================================================================
// Module   : restador_serie
// Brief    : Bit-serial subtractor computing a - b - bi one bit per clock
//            through a single full-subtractor cell and a registered borrow,
//            with an iniciar/listo/valido handshake.
//            Optional build macro: RESTADOR_SERIE_SAT_EN (unsigned saturation
//            of d to 0 when the final borrow is 1).
// Revision : 1.0 - initial release
// ============================================================================
module restador_serie #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iniciar,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             listo,
   output logic             valido,
   output logic [WIDTH-1:0] d,
   output logic             bo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] REPOSO  = 2'd0;
   localparam logic [1:0] CALCULO = 2'd1;
   localparam logic [1:0] FIN     = 2'd2;

   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_q,    res_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] d_q,      d_d;
   logic             bo_q,     bo_d;
   logic             valido_q, valido_d;

   // Single full-subtractor cell working on the current LSBs and the borrow.
   logic bit_x, bit_y, bit_diff, bit_borrow;
   assign bit_x      = a_sh_q[0];
   assign bit_y      = b_sh_q[0];
   assign bit_diff   = bit_x ^ bit_y ^ borrow_q;
   assign bit_borrow = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & borrow_q);

   // Next-state logic: accept in REPOSO, one bit per cycle in CALCULO, commit in FIN.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      d_d      = d_q;
      bo_d     = bo_q;
      valido_d = 1'b0;
      case (state_q)
         REPOSO: begin
            if (iniciar) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = bi;
               cnt_d    = '0;
               state_d  = CALCULO;
            end
         end
         CALCULO: begin
            res_d    = {bit_diff, res_q[WIDTH-1:1]};
            borrow_d = bit_borrow;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            // Counter stops at WIDTH-1 so it never wraps for any legal WIDTH.
            if (cnt_q == C_LAST) begin
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         FIN: begin
`ifdef RESTADOR_SERIE_SAT_EN
            d_d = borrow_q ? '0 : res_q;
`else
            d_d = res_q;
`endif
            bo_d     = borrow_q;
            valido_d = 1'b1;
            state_d  = REPOSO;
         end
         default: begin
            state_d = REPOSO;
         end
      endcase
   end

   // State and datapath registers with asynchronous abort on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= REPOSO;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         d_q      <= '0;
         bo_q     <= 1'b0;
         valido_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         d_q      <= d_d;
         bo_q     <= bo_d;
         valido_q <= valido_d;
      end
   end

   assign listo  = (state_q == REPOSO);
   assign valido = valido_q;
   assign d      = d_q;
   assign bo     = bo_q;

endmodule
`default_nettype wire
